timing_loop_nco: RTL



---
 rtl/timing_loop_nco.sv | 132 +++++++++++++
 1 files changed

// File: rtl/timing_loop_nco.sv
// timing_loop_nco
//   Symbol-timing loop controller. Takes the zero-crossing detector error
//   stream, gates it to the on-time interpolant, filters it with a
//   proportional-integral loop filter and drives a modulo-1 decrementing NCO
//   that produces the interpolation strobe and fractional interval mu
//   (nominal 2 samples/symbol).
//
//   Optional feature macro: TIMING_LOOP_FREEZE_EN adds the freeze input, which
//   holds the loop filter while the NCO keeps running on the held step.
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-low
//   sample_valid  input sample available; NCO advances one step per high cycle
//   e_k           signed timing error from the detector
//   e_valid       e_k qualifier (detector valid)
//   freeze        hold loop filter (only with TIMING_LOOP_FREEZE_EN)
//   strobe        one-cycle pulse: interpolator must produce an interpolant
//   mu            fractional interval, Q0.NCO_WIDTH, held between strobes
//   v_out         signed loop-filter output, for debug / lock monitoring
module timing_loop_nco #(
  parameter int DATA_WIDTH = 16,
  parameter int NCO_WIDTH  = 16,
  parameter int W_NOM      = 2 ** (NCO_WIDTH - 1),
  parameter int KP_SHIFT   = 4,
  parameter int KI_SHIFT   = 10,
  parameter int INTEG_LIM  = 2048,
  parameter int V_LIM      = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] e_k,
  input  logic                  e_valid,
`ifdef TIMING_LOOP_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic                  strobe,
  output logic [NCO_WIDTH-1:0]  mu,
  output logic [NCO_WIDTH:0]    v_out
);

  localparam int IW = 24;

  localparam logic signed [IW:0]   INTEG_LIM_S = (IW + 1)'(INTEG_LIM);
  localparam logic signed [IW:0]   V_LIM_S     = (IW + 1)'(V_LIM);
  localparam logic signed [IW-1:0] W_NOM_S     = IW'(W_NOM);

  // Clamp a one-bit-wider sum to +/-lim; sticks at the limit, never wraps.
  function automatic logic signed [IW-1:0] sat(input logic signed [IW:0] x,
                                               input logic signed [IW:0] lim);
    logic signed [IW:0] r;
    if (x > lim)       r = lim;
    else if (x < -lim) r = -lim;
    else               r = x;
    return r[IW-1:0];
  endfunction

  logic                  sym_phase;
  logic signed [IW-1:0]  integ;
  logic signed [IW-1:0]  v;
  logic [NCO_WIDTH-1:0]  eta;

  logic signed [IW-1:0]  e_ext;
  logic signed [IW-1:0]  prop;
  logic signed [IW-1:0]  iinc;
  logic signed [IW:0]    integ_sum;
  logic signed [IW-1:0]  integ_nxt;
  logic signed [IW:0]    v_sum;
  logic signed [IW-1:0]  v_nxt;
  logic                  accept;

  logic signed [IW-1:0]  w;
  logic signed [IW-1:0]  eta_ext;
  logic                  underflow;
  logic [NCO_WIDTH-1:0]  eta_nxt;
  logic [NCO_WIDTH-1:0]  mu_nxt;

  // Loop filter (combinational part)
  always_comb begin
    e_ext     = {{(IW - DATA_WIDTH){e_k[DATA_WIDTH-1]}}, e_k};
    prop      = e_ext >>> KP_SHIFT;
    iinc      = e_ext >>> KI_SHIFT;
    integ_sum = {integ[IW-1], integ} + {iinc[IW-1], iinc};
    integ_nxt = sat(integ_sum, INTEG_LIM_S);
    v_sum     = {prop[IW-1], prop} + {integ_nxt[IW-1], integ_nxt};
    v_nxt     = sat(v_sum, V_LIM_S);
    // Only the on-time interpolant (second of each e_valid pair) is used.
`ifdef TIMING_LOOP_FREEZE_EN
    accept    = e_valid & sym_phase & ~freeze;
`else
    accept    = e_valid & sym_phase;
`endif
  end

  // NCO (combinational part); uses the registered v, so an error accepted
  // in the same cycle only affects the following steps.
  always_comb begin
    w         = W_NOM_S + v;
    eta_ext   = {{(IW - NCO_WIDTH){1'b0}}, eta};
    underflow = eta_ext < w;
    eta_nxt   = eta - w[NCO_WIDTH-1:0];
    // mu ~ eta/W with W ~ 0.5, taken from the pre-update eta.
    mu_nxt    = {eta[NCO_WIDTH-2:0], 1'b0};
  end

  // Registered state: symbol phase, loop filter, NCO and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_phase <= 1'b0;
      integ     <= '0;
      v         <= '0;
      eta       <= '0;
      strobe    <= 1'b0;
      mu        <= '0;
    end else begin
      if (e_valid) sym_phase <= ~sym_phase;
      if (accept) begin
        integ <= integ_nxt;
        v     <= v_nxt;
      end
      strobe <= sample_valid & underflow;
      if (sample_valid) begin
        eta <= eta_nxt;
        if (underflow) mu <= mu_nxt;
      end
    end
  end

  assign v_out = v[NCO_WIDTH:0];

endmodule
